// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I-subset main controller with MemReady stalls
// Define ILLEGAL_TRAP_EN to add the TRAP state and the IllegalInstr output.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         Opcode,
  input  logic [2:0]         Funct3,
  input  logic               Funct7b5,
  input  logic               ZeroFlag,
  input  logic               SignFlag,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         AluControl,
  output logic [STATE_W-1:0] DbgState
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               IllegalInstr
`endif
);
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, alu_i, alu_r;
  logic f3_bad, taken;
  assign f3_bad = Funct3[2:1] == 2'b01;
  assign alu_i = f3_bad ? 3'b000 : Funct3;
  assign alu_r = (Funct3 == 3'b000 && Funct7b5) ? 3'b010 : alu_i;
  assign taken = (Funct3 == 3'b000 &&  ZeroFlag) || (Funct3 == 3'b001 && !ZeroFlag) ||
                 (Funct3 == 3'b100 &&  SignFlag) || (Funct3 == 3'b101 && !SignFlag);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    pc_write = 1'b0;
    adr_src = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_control = 3'b000;
    case (state_q)
      FETCH: begin
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_write = MemReady;
        pc_write = MemReady;
        state_d = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d = (Opcode == 7'b0000011 || Opcode == 7'b0100011) ? MEMADR :
                  Opcode == 7'b0110011 ? EXECR :
                  Opcode == 7'b0010011 ? EXECI :
                  Opcode == 7'b1100011 ? BRANCH :
                  Opcode == 7'b1101111 ? JAL :
                  TRAP_EN ? TRAP : FETCH;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d = Opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_write = 1'b1;
        state_d = MemReady ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_control = alu_r;
        state_d = (TRAP_EN && f3_bad) ? TRAP : ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_control = alu_i;
        state_d = (TRAP_EN && f3_bad) ? TRAP : ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_control = 3'b010;
        pc_write = taken;
        state_d = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
        state_d = ALUWB;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  // Gate every output with rst_n so an abandoned instruction can never write.
  assign PCWrite = rst_n & pc_write;
  assign AdrSrc = rst_n & adr_src;
  assign MemWrite = rst_n & mem_write;
  assign IRWrite = rst_n & ir_write;
  assign RegWrite = rst_n & reg_write;
  assign ResultSrc = rst_n ? result_src : 2'b00;
  assign ALUSrcA = rst_n ? alu_src_a : 2'b00;
  assign ALUSrcB = rst_n ? alu_src_b : 2'b00;
  assign AluControl = rst_n ? alu_control : 3'b000;
  assign DbgState = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign IllegalInstr = rst_n & (state_q == TRAP);
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: scoreboard bench for multicycle_control_fsm
// Stimulus pushes one expected output vector per cycle; the negedge monitor pops and compares.
module tb_multicycle_control_fsm;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic Funct7b5, ZeroFlag, SignFlag, MemReady;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ill;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] AluControl;
  logic [3:0] DbgState;
  logic [18:0] exp_q[$];
  logic [18:0] f_ok, f_stall, dec, madr, aluwb, mwb, trap;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .ZeroFlag(ZeroFlag), .SignFlag(SignFlag), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .AluControl(AluControl), .DbgState(DbgState)
`ifdef ILLEGAL_TRAP_EN
    , .IllegalInstr(ill)
`endif
  );
`ifndef ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif
  wire [18:0] got = {DbgState, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, AluControl, ill};
  function automatic logic [18:0] v(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, a, b, input logic [2:0] alu,
                                    input logic il = 1'b0);
    return {st, pcw, adr, mw, irw, rw, rs, a, b, alu, il};
  endfunction
  task automatic chk(input string name, input logic [18:0] g, input logic [18:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, g, e);
    end
  endtask
  always @(negedge clk)
    if (exp_q.size() > 0) chk("cycle_vec", got, exp_q.pop_front());
  task automatic cyc(input logic mr, input logic [18:0] e);
    MemReady = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    Opcode = op;
    Funct3 = f3;
    Funct7b5 = f7;
  endtask
  task automatic alu_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [2:0] alu);
    set_ins(op, f3, f7);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, op[5] ? v(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu)
                    : v(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu));
    cyc(1'b1, aluwb);
  endtask
  task automatic br(input logic [2:0] f3, input logic z, input logic s, input logic pcw);
    set_ins(7'b1100011, f3, 1'b0);
    ZeroFlag = z;
    SignFlag = s;
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, v(4'd9, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010));
  endtask
  initial begin
    f_ok = v(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000);
    f_stall = v(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000);
    dec = v(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000);
    madr = v(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000);
    mwb = v(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000);
    aluwb = v(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
    trap = v(4'd11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
    set_ins(7'b0, 3'b0, 1'b0);
    ZeroFlag = 1'b0;
    SignFlag = 1'b0;
    MemReady = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 19'd0);
    cyc(1'b1, 19'd0);
    rst_n = 1'b1;
    alu_ins(7'b0110011, 3'b000, 1'b1, 3'b010);
    alu_ins(7'b0110011, 3'b111, 1'b0, 3'b111);
    alu_ins(7'b0110011, 3'b001, 1'b0, 3'b001);
    alu_ins(7'b0010011, 3'b000, 1'b1, 3'b000);
    alu_ins(7'b0010011, 3'b100, 1'b0, 3'b100);
    alu_ins(7'b0010011, 3'b101, 1'b1, 3'b101);
    alu_ins(7'b0010011, 3'b110, 1'b0, 3'b110);
`ifndef ILLEGAL_TRAP_EN
    alu_ins(7'b0110011, 3'b010, 1'b0, 3'b000);
    alu_ins(7'b0010011, 3'b011, 1'b0, 3'b000);
`endif
    // lw with three wait cycles in MEMREAD: 8 cycles total
    set_ins(7'b0000011, 3'b010, 1'b0);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, madr);
    repeat (3) cyc(1'b0, v(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc(1'b1, v(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc(1'b1, mwb);
    set_ins(7'b0100011, 3'b010, 1'b0);
    cyc(1'b0, f_stall);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, madr);
    repeat (2) cyc(1'b0, v(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc(1'b1, v(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    br(3'b000, 1'b1, 1'b0, 1'b1);
    br(3'b000, 1'b0, 1'b0, 1'b0);
    br(3'b001, 1'b0, 1'b1, 1'b1);
    br(3'b001, 1'b1, 1'b0, 1'b0);
    br(3'b100, 1'b0, 1'b1, 1'b1);
    br(3'b100, 1'b1, 1'b0, 1'b0);
    br(3'b101, 1'b0, 1'b1, 1'b0);
    br(3'b101, 1'b0, 1'b0, 1'b1);
    br(3'b110, 1'b1, 1'b1, 1'b0);
    set_ins(7'b1101111, 3'b000, 1'b0);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, v(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000));
    cyc(1'b1, aluwb);
`ifndef ILLEGAL_TRAP_EN
    set_ins(7'b1111111, 3'b000, 1'b0);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b0, f_stall);
`endif
    // asynchronous reset in the middle of a stalled store
    set_ins(7'b0100011, 3'b010, 1'b0);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, madr);
    cyc(1'b0, v(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    MemReady = 1'b0;
    #1;
    chk("memwrite_before_rst", {18'd0, MemWrite}, 19'd1);
    rst_n = 1'b0;
    #1;
    chk("memwrite_async_rst", {18'd0, MemWrite}, 19'd0);
    chk("state_async_rst", {15'd0, DbgState}, 19'd0);
    cyc(1'b1, 19'd0);
    rst_n = 1'b1;
    #1;
    chk("state_after_rst", {15'd0, DbgState}, 19'd0);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, madr);
    cyc(1'b1, v(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
`ifdef ILLEGAL_TRAP_EN
    set_ins(7'b1111111, 3'b000, 1'b0);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    repeat (3) cyc(1'b1, trap);
    rst_n = 1'b0;
    cyc(1'b1, 19'd0);
    rst_n = 1'b1;
    set_ins(7'b0110011, 3'b011, 1'b0);
    cyc(1'b1, f_ok);
    cyc(1'b1, dec);
    cyc(1'b1, v(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000));
    repeat (2) cyc(1'b1, trap);
`endif
    repeat (2) @(posedge clk);
    chk("queue_drain", exp_q.size(), 19'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
